// File: rtl/linked_list_pkg.sv
// Shared types for the on-chip linked list: node format, null address and removal FSM states.
package linked_list_pkg;

  localparam int DATA_WIDTH = 4;
  localparam int ADDR_WIDTH = 4;

  localparam logic [ADDR_WIDTH-1:0] NULL_ADDR = '0;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] next;
  } node_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CHECK,
    ST_UNLINK,
    ST_DONE
  } remove_state_t;

endpackage

// File: rtl/linked_list_remove_if.sv
// Bundles the node write path, the removal request/response handshake and the debug read port.
interface linked_list_remove_if;
  import linked_list_pkg::*;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] wr_next;

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_head;
  logic [DATA_WIDTH-1:0] req_key;

  logic                  rsp_valid;
  logic                  rsp_found;
  logic                  rsp_error;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic [ADDR_WIDTH-1:0] rsp_new_head;

  logic [ADDR_WIDTH-1:0] dbg_addr;
  logic [DATA_WIDTH-1:0] dbg_data;
  logic [ADDR_WIDTH-1:0] dbg_next;

  modport master (
    output wr_en, wr_addr, wr_data, wr_next,
    output req_valid, req_head, req_key,
    input  req_ready,
    input  rsp_valid, rsp_found, rsp_error, rsp_addr, rsp_new_head,
    output dbg_addr,
    input  dbg_data, dbg_next
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_next,
    input  req_valid, req_head, req_key,
    output req_ready,
    output rsp_valid, rsp_found, rsp_error, rsp_addr, rsp_new_head,
    input  dbg_addr,
    output dbg_data, dbg_next
  );

endinterface

// File: rtl/linked_list_mem.sv
// Node storage: one synchronous read port, one write port, one combinational debug read port.
// Read data appears the cycle after rd_en; contents are never reset.
module linked_list_mem
  import linked_list_pkg::*;
(
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output node_t                 rd_node,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  node_t                 wr_node,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output node_t                 dbg_node
);

  node_t mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_node;
    end
    if (rd_en) begin
      rd_node <= mem[rd_addr];
    end
  end

  assign dbg_node = mem[dbg_addr];

endmodule

// File: rtl/linked_list_remove.sv
// Walks a list from the requested head and unlinks the first node whose data matches the key.
// Latency 2k+4 for a match at node k; one request in flight, req_ready low until the cycle after the response.
module linked_list_remove
  import linked_list_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  linked_list_remove_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] STEP_MAX = '1;

  remove_state_t         state;
  logic                  req_ready_q;
  logic [ADDR_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] key_q;
  logic [ADDR_WIDTH-1:0] cur;
  logic [ADDR_WIDTH-1:0] prev;
  logic [DATA_WIDTH-1:0] prev_data;
  logic [ADDR_WIDTH-1:0] cur_next;
  logic [ADDR_WIDTH-1:0] steps;

  logic                  rsp_valid_q;
  logic                  rsp_found_q;
  logic                  rsp_error_q;
  logic [ADDR_WIDTH-1:0] rsp_addr_q;
  logic [ADDR_WIDTH-1:0] rsp_new_head_q;

  node_t                 rd_node;
  node_t                 dbg_node;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  node_t                 mem_wnode;
  logic                  unlink_wr;

  // The UNLINK rewrite owns the write port; external writes only land while idle.
  assign unlink_wr = (state == ST_UNLINK) && (prev != NULL_ADDR);
  assign mem_we    = unlink_wr || ((state == ST_IDLE) && bus.wr_en);
  assign mem_waddr = unlink_wr ? prev : bus.wr_addr;
  assign mem_wnode = unlink_wr ? node_t'{data: prev_data, next: cur_next}
                               : node_t'{data: bus.wr_data, next: bus.wr_next};

  linked_list_mem u_mem (
    .clk      (clk),
    .rd_en    (state == ST_READ),
    .rd_addr  (cur),
    .rd_node  (rd_node),
    .wr_en    (mem_we),
    .wr_addr  (mem_waddr),
    .wr_node  (mem_wnode),
    .dbg_addr (bus.dbg_addr),
    .dbg_node (dbg_node)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      req_ready_q    <= 1'b1;
      head_q         <= '0;
      key_q          <= '0;
      cur            <= '0;
      prev           <= '0;
      prev_data      <= '0;
      cur_next       <= '0;
      steps          <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_found_q    <= 1'b0;
      rsp_error_q    <= 1'b0;
      rsp_addr_q     <= '0;
      rsp_new_head_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            head_q      <= bus.req_head;
            key_q       <= bus.req_key;
            cur         <= bus.req_head;
            prev        <= NULL_ADDR;
            steps       <= '0;
            req_ready_q <= 1'b0;
            if (bus.req_head == NULL_ADDR) begin
              state          <= ST_DONE;
              rsp_valid_q    <= 1'b1;
              rsp_found_q    <= 1'b0;
              rsp_error_q    <= 1'b0;
              rsp_addr_q     <= NULL_ADDR;
              rsp_new_head_q <= NULL_ADDR;
            end else begin
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (rd_node.data == key_q) begin
            cur_next <= rd_node.next;
            state    <= ST_UNLINK;
          end else if ((rd_node.next == NULL_ADDR) || (steps == STEP_MAX)) begin
            // Running out of steps with a live next pointer means the list never terminates.
            state          <= ST_DONE;
            rsp_valid_q    <= 1'b1;
            rsp_found_q    <= 1'b0;
            rsp_error_q    <= (rd_node.next != NULL_ADDR);
            rsp_addr_q     <= NULL_ADDR;
            rsp_new_head_q <= head_q;
          end else begin
            prev      <= cur;
            prev_data <= rd_node.data;
            cur       <= rd_node.next;
            steps     <= steps + 1'b1;
            state     <= ST_READ;
          end
        end
        ST_UNLINK: begin
          state          <= ST_DONE;
          rsp_valid_q    <= 1'b1;
          rsp_found_q    <= 1'b1;
          rsp_error_q    <= 1'b0;
          rsp_addr_q     <= cur;
          rsp_new_head_q <= (prev == NULL_ADDR) ? cur_next : head_q;
        end
        ST_DONE: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state       <= ST_IDLE;
        end
        default: begin
          state       <= ST_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_found    = rsp_found_q;
  assign bus.rsp_error    = rsp_error_q;
  assign bus.rsp_addr     = rsp_addr_q;
  assign bus.rsp_new_head = rsp_new_head_q;
  assign bus.dbg_data     = dbg_node.data;
  assign bus.dbg_next     = dbg_node.next;

endmodule

// File: tb/tb_linked_list_remove.sv
// Self-checking bench for linked_list_remove: directed list scenarios plus randomized lists
// compared against an array-based model of the list and its removal timing.
module tb_linked_list_remove;
  import linked_list_pkg::*;

  typedef logic [ADDR_WIDTH-1:0] a_t;
  typedef logic [DATA_WIDTH-1:0] d_t;

  logic clk = 1'b0;
  logic rst_n;
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  d_t ref_data [16];
  a_t ref_next [16];

  d_t va, vb, vc, vd, ve;

  linked_list_remove_if bus ();

  linked_list_remove dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: walk the arrays, apply the unlink and return the cycle the response should appear in.
  function automatic void model_remove(input a_t head, input d_t key,
                                       output logic found, output logic err,
                                       output a_t addr, output a_t nh, output int lat);
    a_t  cur;
    a_t  prv;
    bit  done;
    found = 1'b0; err = 1'b0; addr = '0; nh = head; lat = 1;
    cur = head; prv = '0; done = (head == '0);
    for (int k = 0; k < 16 && !done; k++) begin
      if (ref_data[cur] == key) begin
        found = 1'b1; addr = cur; lat = 2 * k + 4; done = 1'b1;
        if (prv == '0) nh = ref_next[cur];
        else ref_next[prv] = ref_next[cur];
      end else if (ref_next[cur] == '0) begin
        lat = 2 * k + 3; done = 1'b1;
      end else if (k == 15) begin
        err = 1'b1; lat = 2 * k + 3; done = 1'b1;
      end else begin
        prv = cur; cur = ref_next[cur];
      end
    end
  endfunction

  task automatic wr_node(input a_t a, input d_t d, input a_t n);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_next = n;
    @(negedge clk);
    bus.wr_en = 1'b0;
    ref_data[a] = d; ref_next[a] = n;
  endtask

  task automatic load_base();
    wr_node(4'd3, va, 4'd5);
    wr_node(4'd5, vb, 4'd9);
    wr_node(4'd9, vc, 4'd0);
  endtask

  // Drives one request (optionally with a same-cycle node write) and records what came back.
  task automatic issue(input a_t head, input d_t key, input bit do_wr,
                       input a_t wa, input d_t wd, input a_t wn,
                       output int lat, output logic found, output logic err,
                       output a_t addr, output a_t nh, output logic rdy1, output bit pulse_ok);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_head = head; bus.req_key = key;
    if (do_wr) begin
      bus.wr_en = 1'b1; bus.wr_addr = wa; bus.wr_data = wd; bus.wr_next = wn;
    end
    lat = -1; pulse_ok = 1'b0; found = 1'bx; err = 1'bx; addr = 'x; nh = 'x; rdy1 = 1'bx;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0; bus.wr_en = 1'b0;
      if (c == 1) rdy1 = bus.req_ready;
      if (bus.rsp_valid) begin
        lat = c; found = bus.rsp_found; err = bus.rsp_error;
        addr = bus.rsp_addr; nh = bus.rsp_new_head;
        break;
      end
    end
    if (lat > 0) begin
      @(negedge clk);
      pulse_ok = !bus.rsp_valid && bus.req_ready && (bus.rsp_addr === addr)
                 && (bus.rsp_new_head === nh);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_cnt++; if (bus.req_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", bus.req_ready); else pass_cnt++;
    chk_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus.rsp_valid); else pass_cnt++;
    chk_cnt++; if (bus.rsp_found !== 1'b0) $display("FAIL reset_found got %b exp 0", bus.rsp_found); else pass_cnt++;
    chk_cnt++; if (bus.rsp_error !== 1'b0) $display("FAIL reset_error got %b exp 0", bus.rsp_error); else pass_cnt++;
    chk_cnt++; if (bus.rsp_addr !== '0) $display("FAIL reset_addr got %0d exp 0", bus.rsp_addr); else pass_cnt++;
    chk_cnt++; if (bus.rsp_new_head !== '0) $display("FAIL reset_head got %0d exp 0", bus.rsp_new_head); else pass_cnt++;
    for (int a = 0; a < 16; a++) wr_node(a_t'(a), d_t'($urandom_range(0, 15)), '0);
  endtask

  task automatic test_remove_mid();
    int lat, elat; logic f, e, r1, ef, ee; a_t ad, nh, ead, enh; bit p;
    load_base();
    issue(4'd3, vb, 0, '0, '0, '0, lat, f, e, ad, nh, r1, p);
    model_remove(4'd3, vb, ef, ee, ead, enh, elat);
    chk_cnt++; if (lat !== 6 || elat != 6) $display("FAIL mid_latency got %0d exp 6 (model %0d)", lat, elat); else pass_cnt++;
    chk_cnt++; if (f !== ef || e !== ee) $display("FAIL mid_flags got f%b e%b exp f%b e%b", f, e, ef, ee); else pass_cnt++;
    chk_cnt++; if (ad !== ead) $display("FAIL mid_addr got %0d exp %0d", ad, ead); else pass_cnt++;
    chk_cnt++; if (nh !== enh) $display("FAIL mid_new_head got %0d exp %0d", nh, enh); else pass_cnt++;
    chk_cnt++; if (r1 !== 1'b0) $display("FAIL mid_ready_busy got %b exp 0", r1); else pass_cnt++;
    chk_cnt++; if (p !== 1'b1) $display("FAIL mid_pulse got %b exp 1", p); else pass_cnt++;
    bus.dbg_addr = 4'd3; #1;
    chk_cnt++; if (bus.dbg_next !== ref_next[3] || bus.dbg_data !== va)
      $display("FAIL mid_relink got %0d/%0d exp %0d/%0d", bus.dbg_data, bus.dbg_next, va, ref_next[3]); else pass_cnt++;
  endtask

  task automatic test_remove_head();
    int lat, elat; logic f, e, r1, ef, ee; a_t ad, nh, ead, enh; bit p;
    load_base();
    issue(4'd3, va, 0, '0, '0, '0, lat, f, e, ad, nh, r1, p);
    model_remove(4'd3, va, ef, ee, ead, enh, elat);
    chk_cnt++; if (lat !== elat) $display("FAIL head_latency got %0d exp %0d", lat, elat); else pass_cnt++;
    chk_cnt++; if (f !== ef || ad !== ead) $display("FAIL head_found got %b@%0d exp %b@%0d", f, ad, ef, ead); else pass_cnt++;
    chk_cnt++; if (nh !== enh) $display("FAIL head_new_head got %0d exp %0d", nh, enh); else pass_cnt++;
    chk_cnt++; if (p !== 1'b1) $display("FAIL head_pulse got %b exp 1", p); else pass_cnt++;
    for (int a = 1; a < 16; a++) begin
      bus.dbg_addr = a_t'(a); #1;
      chk_cnt++; if (bus.dbg_data !== ref_data[a] || bus.dbg_next !== ref_next[a])
        $display("FAIL head_mem[%0d] got %0d/%0d exp %0d/%0d", a, bus.dbg_data, bus.dbg_next, ref_data[a], ref_next[a]); else pass_cnt++;
    end
  endtask

  task automatic test_absent();
    int lat, elat; logic f, e, r1, ef, ee; a_t ad, nh, ead, enh; bit p;
    load_base();
    issue(4'd3, vd, 0, '0, '0, '0, lat, f, e, ad, nh, r1, p);
    model_remove(4'd3, vd, ef, ee, ead, enh, elat);
    chk_cnt++; if (lat !== 7 || elat != 7) $display("FAIL absent_latency got %0d exp 7", lat); else pass_cnt++;
    chk_cnt++; if (f !== 1'b0 || e !== 1'b0) $display("FAIL absent_flags got f%b e%b exp f0 e0", f, e); else pass_cnt++;
    chk_cnt++; if (ad !== '0 || nh !== 4'd3) $display("FAIL absent_addr_head got %0d/%0d exp 0/3", ad, nh); else pass_cnt++;
  endtask

  task automatic test_null_head();
    int lat, elat; logic f, e, r1, ef, ee; a_t ad, nh, ead, enh; bit p;
    issue('0, va, 0, '0, '0, '0, lat, f, e, ad, nh, r1, p);
    model_remove('0, va, ef, ee, ead, enh, elat);
    chk_cnt++; if (lat !== 1 || elat != 1) $display("FAIL null_latency got %0d exp 1", lat); else pass_cnt++;
    chk_cnt++; if (f !== 1'b0 || nh !== '0) $display("FAIL null_result got f%b head %0d exp f0 head 0", f, nh); else pass_cnt++;
    chk_cnt++; if (p !== 1'b1) $display("FAIL null_pulse got %b exp 1", p); else pass_cnt++;
  endtask

  task automatic test_cyclic();
    int lat, elat; logic f, e, r1, ef, ee; a_t ad, nh, ead, enh; bit p;
    d_t vf;
    vf = va + 4'd1;
    wr_node(4'd3, va, 4'd3);
    issue(4'd3, vf, 0, '0, '0, '0, lat, f, e, ad, nh, r1, p);
    model_remove(4'd3, vf, ef, ee, ead, enh, elat);
    chk_cnt++; if (lat !== 33 || elat != 33) $display("FAIL cyclic_latency got %0d exp 33", lat); else pass_cnt++;
    chk_cnt++; if (e !== 1'b1 || f !== 1'b0) $display("FAIL cyclic_flags got e%b f%b exp e1 f0", e, f); else pass_cnt++;
    chk_cnt++; if (nh !== 4'd3 || ad !== '0) $display("FAIL cyclic_head_addr got %0d/%0d exp 3/0", nh, ad); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int seen, lat, elat; logic f, e, r1, ef, ee; a_t ad, nh, ead, enh; bit p;
    seen = 0;
    load_base();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_head = 4'd3; bus.req_key = vc;
    @(posedge clk);
    @(negedge clk); bus.req_valid = 1'b0; if (bus.rsp_valid) seen++;
    @(negedge clk); if (bus.rsp_valid) seen++;
    @(negedge clk); if (bus.rsp_valid) seen++; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk_cnt++; if (bus.req_ready !== 1'b1) $display("FAIL rstmid_ready got %b exp 1", bus.req_ready); else pass_cnt++;
    repeat (10) begin @(negedge clk); if (bus.rsp_valid) seen++; end
    chk_cnt++; if (seen !== 0) $display("FAIL rstmid_no_rsp got %0d pulses exp 0", seen); else pass_cnt++;
    for (int a = 1; a < 16; a++) begin
      bus.dbg_addr = a_t'(a); #1;
      chk_cnt++; if (bus.dbg_data !== ref_data[a] || bus.dbg_next !== ref_next[a])
        $display("FAIL rstmid_mem[%0d] got %0d/%0d exp %0d/%0d", a, bus.dbg_data, bus.dbg_next, ref_data[a], ref_next[a]); else pass_cnt++;
    end
    // Same-cycle write and request: the traversal must see the new node 9.
    issue(4'd3, ve, 1, 4'd9, ve, 4'd0, lat, f, e, ad, nh, r1, p);
    ref_data[9] = ve; ref_next[9] = '0;
    model_remove(4'd3, ve, ef, ee, ead, enh, elat);
    chk_cnt++; if (lat !== 8 || elat != 8) $display("FAIL b2b_latency got %0d exp 8", lat); else pass_cnt++;
    chk_cnt++; if (f !== 1'b1 || ad !== 4'd9) $display("FAIL b2b_found got %b@%0d exp 1@9", f, ad); else pass_cnt++;
    bus.dbg_addr = 4'd5; #1;
    chk_cnt++; if (bus.dbg_next !== '0 || bus.dbg_data !== vb) $display("FAIL b2b_relink got %0d/%0d exp %0d/0", bus.dbg_data, bus.dbg_next, vb); else pass_cnt++;
  endtask

  task automatic test_random();
    int lat, elat, n; logic f, e, r1, ef, ee; a_t ad, nh, ead, enh; bit p;
    a_t pool [15];
    a_t tmp;
    d_t key;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 15; i++) pool[i] = a_t'(i + 1);
      for (int i = 14; i > 0; i--) begin
        int j;
        j = $urandom_range(0, i);
        tmp = pool[i]; pool[i] = pool[j]; pool[j] = tmp;
      end
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++)
        wr_node(pool[i], d_t'($urandom_range(0, 15)), (i == n - 1) ? a_t'(0) : pool[i + 1]);
      if ($urandom_range(0, 1) == 1) key = ref_data[pool[$urandom_range(0, n - 1)]];
      else key = d_t'($urandom_range(0, 15));
      issue(pool[0], key, 0, '0, '0, '0, lat, f, e, ad, nh, r1, p);
      model_remove(pool[0], key, ef, ee, ead, enh, elat);
      chk_cnt++; if (lat !== elat) $display("FAIL rnd%0d_latency got %0d exp %0d", it, lat, elat); else pass_cnt++;
      chk_cnt++; if (f !== ef || e !== ee || ad !== ead || nh !== enh)
        $display("FAIL rnd%0d_rsp got f%b e%b a%0d h%0d exp f%b e%b a%0d h%0d", it, f, e, ad, nh, ef, ee, ead, enh); else pass_cnt++;
      chk_cnt++; if (p !== 1'b1) $display("FAIL rnd%0d_pulse got %b exp 1", it, p); else pass_cnt++;
      for (int a = 1; a < 16; a++) begin
        bus.dbg_addr = a_t'(a); #1;
        chk_cnt++; if (bus.dbg_data !== ref_data[a] || bus.dbg_next !== ref_next[a])
          $display("FAIL rnd%0d_mem[%0d] got %0d/%0d exp %0d/%0d", it, a, bus.dbg_data, bus.dbg_next, ref_data[a], ref_next[a]); else pass_cnt++;
      end
    end
  endtask

  initial begin
    d_t base;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_next = '0;
    bus.req_valid = 1'b0; bus.req_head = '0; bus.req_key = '0; bus.dbg_addr = '0;
    rst_n = 1'b0;
    base = d_t'($urandom_range(0, 15));
    va = base; vb = base + 4'd3; vc = base + 4'd7; vd = base + 4'd11; ve = base + 4'd13;
    test_reset();
    test_remove_mid();
    test_remove_head();
    test_absent();
    test_null_head();
    test_cyclic();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
